// File: rtl/safe_pkg.sv
// rtl/safe_pkg.sv - shared types, key priority and width helpers for the safe lock core
package safe_pkg;

    typedef enum logic [1:0] {
        LOCKED    = 2'd0,
        OPEN      = 2'd1,
        SET_ENTRY = 2'd2,
        LOCKOUT   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE       = 3'd0,
        KEY_OPEN_CLOSE = 3'd1,
        KEY_CLEAR      = 3'd2,
        KEY_SET        = 3'd3,
        KEY_CONFIRM    = 3'd4,
        KEY_DIGIT      = 3'd5
    } key_e;

    // Only the highest-priority pulse of a cycle is allowed to act.
    function automatic key_e key_select(input logic open_close, input logic clear,
                                        input logic set, input logic confirm,
                                        input logic digit_valid);
        if (open_close)       return KEY_OPEN_CLOSE;
        else if (clear)       return KEY_CLEAR;
        else if (set)         return KEY_SET;
        else if (confirm)     return KEY_CONFIRM;
        else if (digit_valid) return KEY_DIGIT;
        else                  return KEY_NONE;
    endfunction

    // Width of a counter that must reach n inclusive.
    function automatic int count_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of a down-counter loaded with n-1.
    function automatic int timer_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/safe_entry_buffer.sv
// rtl/safe_entry_buffer.sv - saturating shift-in buffer for entered digits
module safe_entry_buffer
    import safe_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int DIGIT_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        append_en_i,
    input  logic                        clear_i,
    input  logic                        digit_valid_i,
    input  logic [DIGIT_W-1:0]          digit_i,
    output logic [DIGITS*DIGIT_W-1:0]   entry_o,
    output logic [count_w(DIGITS)-1:0]  entry_count_o,
    output logic                        full_o
);

    localparam int W     = DIGITS * DIGIT_W;
    localparam int CNT_W = count_w(DIGITS);

    logic [W-1:0]     entry_q, entry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;

    assign full = (count_q == CNT_W'(DIGITS));

    always_comb begin
        entry_d = entry_q;
        count_d = count_q;
        if (clear_i) begin
            entry_d = '0;
            count_d = '0;
        end else if (append_en_i && digit_valid_i && !full) begin
            // Truncating the concatenation drops the MS digit and shifts the new one in.
            entry_d = W'({entry_q, digit_i});
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            count_q <= count_d;
        end
    end

    assign entry_o       = entry_q;
    assign entry_count_o = count_q;
    assign full_o        = full;

endmodule

// File: rtl/safe_lock_fsm.sv
// rtl/safe_lock_fsm.sv - lock state machine with password, attempt counter and timed lockout
module safe_lock_fsm
    import safe_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIGIT_W        = 4,
    parameter int MAX_FAIL       = 3,
    parameter int ALARM_CYCLES   = 25_000_000,
    parameter int LOCKOUT_CYCLES = 500_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_open_close,
    input  logic                          key_set,
    input  logic                          key_clear,
    input  logic                          key_confirm,
    input  logic                          digit_valid,
    input  logic [DIGIT_W-1:0]            digit,
    output logic [DIGITS*DIGIT_W-1:0]     entry,
    output logic [count_w(DIGITS)-1:0]    entry_count,
    output logic                          opened,
    output logic                          show_entry,
    output logic                          alarm,
    output logic                          locked_out,
    output logic [count_w(MAX_FAIL)-1:0]  fail_count,
    output logic                          set_err
);

    localparam int W       = DIGITS * DIGIT_W;
    localparam int FAIL_W  = count_w(MAX_FAIL);
    localparam int ALARM_W = timer_w(ALARM_CYCLES);
    localparam int LOCK_W  = timer_w(LOCKOUT_CYCLES);

    state_e              state_q, state_d;
    logic [W-1:0]        pass_q, pass_d;
    logic [FAIL_W-1:0]   fail_q, fail_d, fail_inc;
    logic [ALARM_W-1:0]  atim_q, atim_d;
    logic [LOCK_W-1:0]   ltim_q, ltim_d;
    logic                alarm_q, alarm_d;
    logic                set_err_q, set_err_d;
    logic                opened_q, opened_d;
    logic                show_q, show_d;
    logic                lockout_q, lockout_d;
    logic                buf_clear, buf_append, buf_full;
    key_e                key;

    safe_entry_buffer #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W)) u_entry (
        .clk           (clk),
        .rst_n         (rst_n),
        .append_en_i   (buf_append),
        .clear_i       (buf_clear),
        .digit_valid_i (digit_valid),
        .digit_i       (digit),
        .entry_o       (entry),
        .entry_count_o (entry_count),
        .full_o        (buf_full)
    );

    assign key      = key_select(key_open_close, key_clear, key_set, key_confirm, digit_valid);
    assign fail_inc = fail_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOCKED;
            pass_q    <= '0;
            fail_q    <= '0;
            atim_q    <= '0;
            ltim_q    <= '0;
            alarm_q   <= 1'b0;
            set_err_q <= 1'b0;
            opened_q  <= 1'b0;
            show_q    <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            atim_q    <= atim_d;
            ltim_q    <= ltim_d;
            alarm_q   <= alarm_d;
            set_err_q <= set_err_d;
            opened_q  <= opened_d;
            show_q    <= show_d;
            lockout_q <= lockout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        atim_d     = atim_q;
        ltim_d     = ltim_q;
        alarm_d    = alarm_q;
        set_err_d  = 1'b0;
        buf_clear  = 1'b0;
        buf_append = 1'b0;

        // Single-failure alarm pulse counts down from ALARM_CYCLES-1 to 0.
        if (alarm_q && state_q != LOCKOUT) begin
            if (atim_q == '0) alarm_d = 1'b0;
            else              atim_d  = atim_q - 1'b1;
        end

        unique case (state_q)
            LOCKED: begin
                unique case (key)
                    KEY_OPEN_CLOSE: begin
                        buf_clear = 1'b1;
                        if (buf_full && entry == pass_q) begin
                            state_d = OPEN;
                            fail_d  = '0;
                            alarm_d = 1'b0;
                            atim_d  = '0;
                        end else if (fail_inc == FAIL_W'(MAX_FAIL)) begin
                            state_d = LOCKOUT;
                            fail_d  = fail_inc;
                            ltim_d  = LOCK_W'(LOCKOUT_CYCLES - 1);
                            alarm_d = 1'b1;
                            atim_d  = '0;
                        end else begin
                            fail_d  = fail_inc;
                            alarm_d = 1'b1;
                            atim_d  = ALARM_W'(ALARM_CYCLES - 1);
                        end
                    end
                    KEY_CLEAR: buf_clear  = 1'b1;
                    KEY_DIGIT: buf_append = 1'b1;
                    default: ;
                endcase
            end
            LOCKOUT: begin
                if (ltim_q == '0) begin
                    state_d   = LOCKED;
                    fail_d    = '0;
                    alarm_d   = 1'b0;
                    buf_clear = 1'b1;
                end else begin
                    ltim_d = ltim_q - 1'b1;
                end
            end
            OPEN: begin
                unique case (key)
                    KEY_OPEN_CLOSE: begin state_d = LOCKED; buf_clear = 1'b1; end
                    KEY_CLEAR:      begin pass_d = '0; buf_clear = 1'b1; end
                    KEY_SET:        begin state_d = SET_ENTRY; buf_clear = 1'b1; end
                    default: ;
                endcase
            end
            SET_ENTRY: begin
                unique case (key)
                    KEY_OPEN_CLOSE: begin state_d = LOCKED; buf_clear = 1'b1; end
                    KEY_CLEAR:      buf_clear = 1'b1;
                    KEY_CONFIRM: begin
                        if (buf_full) begin
                            pass_d    = entry;
                            state_d   = OPEN;
                            buf_clear = 1'b1;
                        end else begin
                            set_err_d = 1'b1;
                        end
                    end
                    KEY_DIGIT: buf_append = 1'b1;
                    default: ;
                endcase
            end
            default: state_d = LOCKED;
        endcase
    end

    always_comb begin
        opened_d  = (state_d == OPEN) || (state_d == SET_ENTRY);
        show_d    = (state_d == SET_ENTRY);
        lockout_d = (state_d == LOCKOUT);
    end

    assign opened     = opened_q;
    assign show_entry = show_q;
    assign alarm      = alarm_q;
    assign locked_out = lockout_q;
    assign fail_count = fail_q;
    assign set_err    = set_err_q;

endmodule

// File: tb/tb_safe_lock_fsm.sv
// tb/tb_safe_lock_fsm.sv - directed self-checking bench for safe_lock_fsm
module tb_safe_lock_fsm;

    localparam int DIGITS  = 4;
    localparam int DIGIT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_open_close, key_set, key_clear, key_confirm, digit_valid;
    logic [3:0]  digit;
    logic [15:0] entry;
    logic [2:0]  entry_count;
    logic        opened, show_entry, alarm, locked_out, set_err;
    logic [1:0]  fail_count;

    int   passed = 0;
    int   total  = 0;
    logic alarm_seen = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) if (alarm === 1'b1) alarm_seen = 1'b1;

    safe_lock_fsm #(
        .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(3),
        .ALARM_CYCLES(8), .LOCKOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_open_close(key_open_close), .key_set(key_set),
        .key_clear(key_clear), .key_confirm(key_confirm),
        .digit_valid(digit_valid), .digit(digit),
        .entry(entry), .entry_count(entry_count),
        .opened(opened), .show_entry(show_entry), .alarm(alarm),
        .locked_out(locked_out), .fail_count(fail_count), .set_err(set_err)
    );

    task automatic release_inputs();
        key_open_close = 0; key_set = 0; key_clear = 0; key_confirm = 0;
        digit_valid = 0; digit = 0;
    endtask

    task automatic press(input logic oc, input logic clr, input logic st, input logic cf);
        key_open_close = oc; key_clear = clr; key_set = st; key_confirm = cf;
        @(negedge clk);
        release_inputs();
    endtask

    task automatic send_digit(input logic [3:0] d);
        digit_valid = 1; digit = d;
        @(negedge clk);
        release_inputs();
    endtask

    task automatic enter4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        send_digit(a); send_digit(b); send_digit(c); send_digit(d);
    endtask

    task automatic test_reset();
        release_inputs();
        rst_n = 0;
        repeat (2) @(negedge clk);
        total++;
        if ({opened, show_entry, alarm, locked_out, set_err} !== 5'b0)
            $display("FAIL reset_flags got=%b exp=00000", {opened, show_entry, alarm, locked_out, set_err});
        else passed++;
        total++;
        if ({entry, entry_count, fail_count} !== 21'b0)
            $display("FAIL reset_entry entry=%h count=%0d fail=%0d exp=0", entry, entry_count, fail_count);
        else passed++;
        rst_n = 1;
        @(negedge clk);
        alarm_seen = 0;
    endtask

    task automatic test_default_unlock();
        enter4(0, 0, 0, 0);
        total++;
        if (entry_count !== 3'd4) $display("FAIL unlock_count got=%0d exp=4", entry_count); else passed++;
        press(1, 0, 0, 0);
        total++;
        if (opened !== 1'b1) $display("FAIL unlock_opened got=%b exp=1", opened); else passed++;
        total++;
        if ({entry_count, fail_count} !== 5'b0)
            $display("FAIL unlock_cleared count=%0d fail=%0d exp=0/0", entry_count, fail_count);
        else passed++;
        total++;
        if (alarm_seen !== 1'b0) $display("FAIL unlock_no_alarm got=%b exp=0", alarm_seen); else passed++;
    endtask

    task automatic test_change_password();
        int n;
        press(0, 0, 1, 0);
        total++;
        if ({opened, show_entry} !== 2'b11) $display("FAIL set_show got=%b exp=11", {opened, show_entry}); else passed++;
        enter4(1, 2, 3, 4);
        total++;
        if (entry !== 16'h1234) $display("FAIL set_entry got=%h exp=1234", entry); else passed++;
        press(0, 0, 0, 1);
        total++;
        if ({opened, show_entry, entry_count} !== 5'b10000)
            $display("FAIL confirm_open got=%b exp=10000", {opened, show_entry, entry_count});
        else passed++;
        press(1, 0, 0, 0);
        total++;
        if (opened !== 1'b0) $display("FAIL close got=%b exp=0", opened); else passed++;
        enter4(1, 2, 3, 4);
        press(1, 0, 0, 0);
        total++;
        if (opened !== 1'b1) $display("FAIL new_pw_open got=%b exp=1", opened); else passed++;
        press(1, 0, 0, 0);
        enter4(0, 0, 0, 0);
        press(1, 0, 0, 0);
        total++;
        if ({opened, fail_count} !== 3'b001)
            $display("FAIL old_pw_rejected opened=%b fail=%0d exp=0/1", opened, fail_count);
        else passed++;
        n = 0;
        while (alarm === 1'b1 && n < 50) begin n++; @(negedge clk); end
        total++;
        if (n !== 8) $display("FAIL alarm_len got=%0d exp=8", n); else passed++;
    endtask

    task automatic test_lockout();
        int n;
        logic dropped;
        enter4(1, 2, 3, 4);
        press(1, 0, 0, 0);
        total++;
        if ({opened, fail_count, alarm} !== 4'b1000)
            $display("FAIL reopen got=%b exp=1000", {opened, fail_count, alarm});
        else passed++;
        press(1, 0, 0, 0);
        for (int i = 1; i <= 2; i++) begin
            enter4(9, 9, 9, 9);
            press(1, 0, 0, 0);
            total++;
            if (fail_count !== 2'(i) || locked_out !== 1'b0)
                $display("FAIL wrong_attempt_%0d fail=%0d lo=%b exp=%0d/0", i, fail_count, locked_out, i);
            else passed++;
        end
        enter4(9, 9, 9, 9);
        press(1, 0, 0, 0);
        n = 0;
        dropped = 0;
        while (locked_out === 1'b1 && n < 100) begin
            n++;
            if (alarm !== 1'b1) dropped = 1;
            if (n == 3) begin digit_valid = 1; digit = 4'h1; end
            if (n == 5) key_open_close = 1;
            if (n == 7) key_set = 1;
            @(negedge clk);
            release_inputs();
        end
        total++;
        if (n !== 20) $display("FAIL lockout_len got=%0d exp=20", n); else passed++;
        total++;
        if (dropped !== 1'b0) $display("FAIL lockout_alarm dropped=%b exp=0", dropped); else passed++;
        total++;
        if ({opened, alarm, fail_count, entry_count} !== 7'b0)
            $display("FAIL lockout_exit opened=%b alarm=%b fail=%0d count=%0d exp=0", opened, alarm, fail_count, entry_count);
        else passed++;
        enter4(1, 2, 3, 4);
        press(1, 0, 0, 0);
        total++;
        if (opened !== 1'b1) $display("FAIL post_lockout_open got=%b exp=1", opened); else passed++;
    endtask

    task automatic test_short_confirm_overflow();
        press(0, 0, 1, 0);
        send_digit(5); send_digit(6);
        press(0, 0, 0, 1);
        total++;
        if ({set_err, show_entry, entry_count} !== 5'b11010)
            $display("FAIL short_confirm got=%b exp=11010", {set_err, show_entry, entry_count});
        else passed++;
        @(negedge clk);
        total++;
        if (set_err !== 1'b0) $display("FAIL set_err_pulse got=%b exp=0", set_err); else passed++;
        press(0, 1, 0, 0);
        total++;
        if ({show_entry, entry_count} !== 4'b1000)
            $display("FAIL set_clear got=%b exp=1000", {show_entry, entry_count});
        else passed++;
        send_digit(6); send_digit(7); send_digit(8); send_digit(9); send_digit(10); send_digit(11);
        total++;
        if (entry_count !== 3'd4 || entry !== 16'h6789)
            $display("FAIL overflow count=%0d entry=%h exp=4/6789", entry_count, entry);
        else passed++;
        press(1, 0, 0, 0);
        total++;
        if ({opened, show_entry} !== 2'b00) $display("FAIL abandon got=%b exp=00", {opened, show_entry}); else passed++;
        enter4(1, 2, 3, 4);
        press(1, 0, 0, 0);
        total++;
        if (opened !== 1'b1) $display("FAIL pw_unchanged got=%b exp=1", opened); else passed++;
    endtask

    task automatic test_simultaneous();
        press(1, 0, 1, 0);
        total++;
        if ({opened, show_entry} !== 2'b00) $display("FAIL oc_over_set got=%b exp=00", {opened, show_entry}); else passed++;
        send_digit(1); send_digit(2);
        digit_valid = 1; digit = 4'h3; key_clear = 1;
        @(negedge clk);
        release_inputs();
        total++;
        if (entry_count !== 3'd0 || entry !== 16'h0)
            $display("FAIL clear_over_digit count=%0d entry=%h exp=0/0", entry_count, entry);
        else passed++;
    endtask

    task automatic test_async_reset();
        enter4(1, 2, 3, 4);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0);
        send_digit(5);
        #2 rst_n = 0;
        #1;
        total++;
        if ({opened, show_entry, alarm, locked_out, entry_count, entry, fail_count} !== 25'b0)
            $display("FAIL async_reset opened=%b show=%b count=%0d entry=%h exp=0", opened, show_entry, entry_count, entry);
        else passed++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        enter4(0, 0, 0, 0);
        press(1, 0, 0, 0);
        total++;
        if (opened !== 1'b1) $display("FAIL reset_pw_zero got=%b exp=1", opened); else passed++;
    endtask

    initial begin
        test_reset();
        test_default_unlock();
        test_change_password();
        test_lockout();
        test_short_confirm_overflow();
        test_simultaneous();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
